// File: rtl/sdram_responder.sv
// sdram_responder: device side of an SDR SDRAM command bus.
// Decodes commands, tracks open rows per bank, stores write data in a reduced
// on-chip array (high row bits alias) and returns read data after CAS latency.
module sdram_responder #(
   parameter int ROW_BITS = 2,
   parameter int COL_BITS = 10,
   parameter int REF_MIN  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dram_cke,
   input  logic        dram_cs_n,
   input  logic        dram_ras_n,
   input  logic        dram_cas_n,
   input  logic        dram_we_n,
   input  logic [1:0]  dram_ba,
   input  logic [12:0] dram_addr,
   input  logic        dram_ldqm,
   input  logic        dram_udqm,
   inout  wire  [15:0] dram_dq,
   output logic        init_done,
   output logic        err,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   localparam int IDX_W = 2 + ROW_BITS + COL_BITS;
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [7:0] REF_MIN_C = 8'(REF_MIN);

   // {ras_n, cas_n, we_n} encodings
   localparam logic [2:0] CMD_MRS = 3'b000;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_RD  = 3'b101;

   typedef enum logic [1:0] {
      S_UNINIT,
      S_PRECHG,
      S_READY
   } init_state_t;

   init_state_t         state_q, state_d;
   logic [7:0]          ref_cnt_q, ref_cnt_d;
   logic                cl3_q, cl3_d;
   logic [3:0]          bank_open_q, bank_open_d;
   logic [ROW_BITS-1:0] bank_row_q [4];
   logic [ROW_BITS-1:0] bank_row_d [4];
   logic                err_q, err_d;
   logic [15:0]         rd_count_q, rd_count_d;
   logic [15:0]         wr_count_q, wr_count_d;

   // Read pipeline: stage 0 holds valid/mask while the RAM output register
   // holds the data; data joins the pipe from stage 1 onward.
   logic [2:0]          pv_q, pv_d;
   logic [1:0]          pm_q [3];
   logic [1:0]          pm_d [3];
   logic [15:0]         pd_q [2];
   logic [15:0]         pd_d [2];

   logic [2:0]          cmd;
   logic                cmd_valid;
   logic                ready;
   logic                rd_en;
   logic                wr_en;
   logic                flush;
   logic                read_pending;
   logic [1:0]          dqm;
   logic [IDX_W-1:0]    mem_idx;
   wire  [15:0]         mem_rd;
   logic                drive_v;
   logic [1:0]          drive_m;
   logic [15:0]         drive_d;
   logic                unused_addr;

   assign cmd          = {dram_ras_n, dram_cas_n, dram_we_n};
   assign cmd_valid    = dram_cke && !dram_cs_n;
   assign ready        = (state_q == S_READY);
   assign dqm          = {dram_udqm, dram_ldqm};
   assign mem_idx      = {dram_ba, bank_row_q[dram_ba], dram_addr[COL_BITS-1:0]};
   assign read_pending = pv_q[0] || pv_q[1] || (cl3_q && pv_q[2]);
   assign unused_addr  = ^dram_addr;

   // Command decode, init sequencing, bank tracking and pipeline advance
   always_comb begin
      state_d     = state_q;
      ref_cnt_d   = ref_cnt_q;
      cl3_d       = cl3_q;
      bank_open_d = bank_open_q;
      bank_row_d  = bank_row_q;
      err_d       = err_q;
      rd_count_d  = rd_count_q;
      wr_count_d  = wr_count_q;
      rd_en       = 1'b0;
      wr_en       = 1'b0;
      flush       = 1'b0;

      if (cmd_valid) begin
         case (cmd)
            CMD_PRE: begin
               if (dram_addr[10]) begin
                  bank_open_d = 4'b0000;
                  if (state_q == S_UNINIT) begin
                     state_d   = S_PRECHG;
                     ref_cnt_d = 8'd0;
                  end
               end else begin
                  bank_open_d[dram_ba] = 1'b0;
               end
            end
            CMD_REF: begin
               if (|bank_open_q) err_d = 1'b1;
               if (state_q == S_PRECHG && ref_cnt_q != 8'hFF) ref_cnt_d = ref_cnt_q + 8'd1;
            end
            CMD_MRS: begin
               // Mode is latched even when the command is flagged
               if (dram_addr[6:4] == 3'd3) begin
                  cl3_d = 1'b1;
               end else begin
                  cl3_d = 1'b0;
                  if (dram_addr[6:4] != 3'd2) err_d = 1'b1;
               end
               if (dram_addr[2:0] != 3'b000) err_d = 1'b1;
               if (|bank_open_q) err_d = 1'b1;
               if (state_q == S_PRECHG && ref_cnt_q >= REF_MIN_C) begin
                  state_d = S_READY;
               end else if (state_q != S_READY) begin
                  err_d = 1'b1;
               end
            end
            CMD_ACT: begin
               if (!ready) begin
                  err_d = 1'b1;
               end else begin
                  if (bank_open_q[dram_ba]) err_d = 1'b1;
                  bank_open_d[dram_ba] = 1'b1;
                  bank_row_d[dram_ba]  = dram_addr[ROW_BITS-1:0];
               end
            end
            CMD_RD: begin
               if (!ready || !bank_open_q[dram_ba]) begin
                  err_d = 1'b1;
               end else begin
                  rd_en      = 1'b1;
                  rd_count_d = rd_count_q + 16'd1;
                  if (dram_addr[10]) bank_open_d[dram_ba] = 1'b0;
               end
            end
            CMD_WR: begin
               if (!ready || !bank_open_q[dram_ba]) begin
                  err_d = 1'b1;
               end else begin
                  wr_en      = 1'b1;
                  wr_count_d = wr_count_q + 16'd1;
                  if (dram_addr[10]) bank_open_d[dram_ba] = 1'b0;
                  // A read still in flight would collide with the write data
                  if (read_pending) begin
                     err_d = 1'b1;
                     flush = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      pv_d    = flush ? 3'b000 : {pv_q[1:0], rd_en};
      pm_d[0] = dqm;
      pm_d[1] = pm_q[0];
      pm_d[2] = pm_q[1];
      pd_d[0] = mem_rd;
      pd_d[1] = pd_q[0];
   end

   // State registers; reset leaves the storage array untouched
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_UNINIT;
         ref_cnt_q   <= 8'd0;
         cl3_q       <= 1'b0;
         bank_open_q <= 4'b0000;
         bank_row_q  <= '{default: '0};
         err_q       <= 1'b0;
         rd_count_q  <= 16'd0;
         wr_count_q  <= 16'd0;
         pv_q        <= 3'b000;
         pm_q        <= '{default: '0};
         pd_q        <= '{default: '0};
      end else begin
         state_q     <= state_d;
         ref_cnt_q   <= ref_cnt_d;
         cl3_q       <= cl3_d;
         bank_open_q <= bank_open_d;
         bank_row_q  <= bank_row_d;
         err_q       <= err_d;
         rd_count_q  <= rd_count_d;
         wr_count_q  <= wr_count_d;
         pv_q        <= pv_d;
         pm_q        <= pm_d;
         pd_q        <= pd_d;
      end
   end

   // Pipeline tap selected by CAS latency
   assign drive_v = cl3_q ? pv_q[2] : pv_q[1];
   assign drive_m = cl3_q ? pm_q[2] : pm_q[1];
   assign drive_d = cl3_q ? pd_q[1] : pd_q[0];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_q;

         // Byte-lane RAM: masked write, registered read
         always_ff @(posedge clk) begin
            if (rst && wr_en && !dqm[gi]) mem[mem_idx] <= dram_dq[gi*8 +: 8];
            if (rd_en) rd_q <= mem[mem_idx];
         end

         assign mem_rd[gi*8 +: 8]  = rd_q;
         assign dram_dq[gi*8 +: 8] = (drive_v && !drive_m[gi]) ? drive_d[gi*8 +: 8] : 8'hzz;
      end
   endgenerate

   assign init_done = ready;
   assign err       = err_q;
   assign rd_count  = rd_count_q;
   assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_sdram_responder.sv
module tb_sdram_responder;

    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [15:0] ZV   = 16'hFFFF;

    localparam logic [2:0] K_DQ  = 3'd0;
    localparam logic [2:0] K_ERR = 3'd1;
    localparam logic [2:0] K_INI = 3'd2;
    localparam logic [2:0] K_RDC = 3'd3;
    localparam logic [2:0] K_WRC = 3'd4;

    typedef struct packed {
        int unsigned at;
        logic [2:0]  kind;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        ldqm, udqm;
    logic        tb_oe;
    logic [15:0] tb_dq;
    wire  [15:0] dq;
    logic        init_done, err;
    logic [15:0] rd_count, wr_count;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb [$];

    assign dq = tb_oe ? tb_dq : 16'hzzzz;
    pullup (dq);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_responder dut (
        .clk(clk), .rst(rst), .dram_cke(cke), .dram_cs_n(cs_n),
        .dram_ras_n(ras_n), .dram_cas_n(cas_n), .dram_we_n(we_n),
        .dram_ba(ba), .dram_addr(addr), .dram_ldqm(ldqm), .dram_udqm(udqm),
        .dram_dq(dq), .init_done(init_done), .err(err),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    function automatic string kname(input logic [2:0] k);
        case (k)
            K_DQ:    return "dq";
            K_ERR:   return "err";
            K_INI:   return "init_done";
            K_RDC:   return "rd_count";
            default: return "wr_count";
        endcase
    endfunction

    always @(negedge clk) begin
        logic [15:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                case (sb[i].kind)
                    K_DQ:    act = dq;
                    K_ERR:   act = {15'd0, err};
                    K_INI:   act = {15'd0, init_done};
                    K_RDC:   act = rd_count;
                    default: act = wr_count;
                endcase
                checks++;
                if (act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got %h, expected %h", kname(sb[i].kind), cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input int unsigned at, input logic [2:0] kind, input logic [15:0] val);
        exp_t e;
        e.at = at; e.kind = kind; e.val = val;
        sb.push_back(e);
    endtask

    task automatic expect_dq(input int unsigned e, input logic [15:0] val);
        push(e - 1, K_DQ, val);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [1:0] m, input logic [15:0] wd, output int unsigned t);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba = b; addr = a; {udqm, ldqm} = m;
        if (c == C_WR) begin
            tb_dq = wd;
            tb_oe = 1'b1;
        end
        @(posedge clk);
        #1;
        t = cyc;
        cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
        ldqm = 1'b0; udqm = 1'b0; tb_oe = 1'b0;
        $display("edge %0d: cmd=%b ba=%0d addr=%h dqm=%b wdata=%h", t, c, b, a, m, wd);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        idle(n);
        rst = 1'b1;
    endtask

    task automatic init_seq(input int nref, input logic [12:0] mode, output int unsigned t);
        int unsigned tt;
        cmd(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0, tt);
        for (int i = 0; i < nref; i++) cmd(C_REF, 2'd0, 13'h0, 2'b00, 16'h0, tt);
        cmd(C_MRS, 2'd0, mode, 2'b00, 16'h0, t);
    endtask

    initial begin
        int unsigned t, t2;
        rst = 1'b0; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
        ba = 2'd0; addr = 13'h0; ldqm = 1'b0; udqm = 1'b0; tb_oe = 1'b0; tb_dq = 16'h0;

        idle(3);
        push(cyc, K_ERR, 16'd0); push(cyc, K_INI, 16'd0);
        push(cyc, K_RDC, 16'd0); push(cyc, K_WRC, 16'd0); push(cyc, K_DQ, ZV);
        rst = 1'b1;

        cmd(C_ACT, 2'd0, 13'h0, 2'b00, 16'h0, t);
        push(t, K_ERR, 16'd1);
        do_reset(2);
        push(cyc, K_ERR, 16'd0);

        init_seq(1, 13'h020, t);
        push(t, K_ERR, 16'd1); push(t, K_INI, 16'd0);
        do_reset(2);

        init_seq(8, 13'h020, t);
        push(t, K_INI, 16'd1); push(t, K_ERR, 16'd0);
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done after init: got %b, expected 1", init_done);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err after init: got %b, expected 0", err);
        end

        cmd(C_ACT, 2'd1, 13'h000, 2'b00, 16'h0, t);
        cmd(C_WR,  2'd1, 13'h005, 2'b00, 16'hBEEF, t);
        cmd(C_RD,  2'd1, 13'h005, 2'b00, 16'h0, t);
        expect_dq(t + 1, ZV); expect_dq(t + 2, 16'hBEEF); expect_dq(t + 3, ZV);
        push(t, K_RDC, 16'd1); push(t, K_WRC, 16'd1);
        idle(4);
        cmd(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0, t);

        cmd(C_MRS, 2'd0, 13'h030, 2'b00, 16'h0, t);
        cmd(C_ACT, 2'd1, 13'h000, 2'b00, 16'h0, t);
        cmd(C_WR,  2'd1, 13'h006, 2'b00, 16'h5A5A, t);
        idle(2);
        cmd(C_RD,  2'd1, 13'h005, 2'b00, 16'h0, t);
        cmd(C_RD,  2'd1, 13'h006, 2'b00, 16'h0, t2);
        expect_dq(t + 2, ZV); expect_dq(t + 3, 16'hBEEF);
        expect_dq(t + 4, 16'h5A5A); expect_dq(t + 5, ZV);
        idle(6);
        push(cyc, K_ERR, 16'd0); push(cyc, K_RDC, 16'd3); push(cyc, K_WRC, 16'd2);
        cmd(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0, t);
        cmd(C_MRS, 2'd0, 13'h020, 2'b00, 16'h0, t);

        cmd(C_ACT, 2'd2, 13'h001, 2'b00, 16'h0, t);
        cmd(C_WR,  2'd2, 13'h00A, 2'b00, 16'hFFFF, t);
        cmd(C_WR,  2'd2, 13'h00A, 2'b10, 16'h1234, t);
        cmd(C_RD,  2'd2, 13'h00A, 2'b00, 16'h0, t);
        expect_dq(t + 2, 16'hFF34);
        idle(3);
        cmd(C_RD,  2'd2, 13'h00A, 2'b01, 16'h0, t);
        expect_dq(t + 2, 16'hFFFF);
        idle(3);
        cmd(C_PRE, 2'd2, 13'h000, 2'b00, 16'h0, t);
        cmd(C_ACT, 2'd2, 13'h005, 2'b00, 16'h0, t);
        cmd(C_RD,  2'd2, 13'h00A, 2'b00, 16'h0, t);
        expect_dq(t + 2, 16'hFF34);
        idle(3);
        push(cyc, K_ERR, 16'd0); push(cyc, K_RDC, 16'd6); push(cyc, K_WRC, 16'd4);

        cmd(C_RD, 2'd3, 13'h000, 2'b00, 16'h0, t);
        push(t, K_ERR, 16'd1); push(t, K_RDC, 16'd6);
        expect_dq(t + 1, ZV); expect_dq(t + 2, ZV); expect_dq(t + 3, ZV);
        idle(4);

        cmd(C_ACT, 2'd1, 13'h000, 2'b00, 16'h0, t);
        cmd(C_RD,  2'd1, 13'h005, 2'b00, 16'h0, t);
        push(t, K_RDC, 16'd7);
        rst = 1'b0;
        idle(1);
        push(cyc, K_ERR, 16'd0); push(cyc, K_INI, 16'd0);
        push(cyc, K_RDC, 16'd0); push(cyc, K_WRC, 16'd0);
        checks++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
            errors++;
            $display("FAIL counts after reset: got rd=%h wr=%h, expected 0", rd_count, wr_count);
        end
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_done after reset: got %b, expected 0", init_done);
        end
        expect_dq(t + 2, ZV);
        idle(2);
        rst = 1'b1;

        init_seq(2, 13'h020, t);
        push(t, K_INI, 16'd1); push(t, K_ERR, 16'd0);
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done after re-init: got %b, expected 1", init_done);
        end
        cmd(C_ACT, 2'd1, 13'h000, 2'b00, 16'h0, t);
        cmd(C_RD,  2'd1, 13'h005, 2'b00, 16'h0, t);
        expect_dq(t + 2, 16'hBEEF);
        cmd(C_ACT, 2'd2, 13'h001, 2'b00, 16'h0, t);
        cmd(C_RD,  2'd2, 13'h00A, 2'b00, 16'h0, t);
        expect_dq(t + 2, 16'hFF34);
        idle(3);

        cmd(C_RD, 2'd1, 13'h405, 2'b00, 16'h0, t);
        push(t, K_ERR, 16'd0);
        expect_dq(t + 2, 16'hBEEF);
        cmd(C_RD, 2'd1, 13'h005, 2'b00, 16'h0, t2);
        push(t2, K_ERR, 16'd1); push(t2, K_RDC, 16'd3);
        expect_dq(t2 + 2, ZV);
        idle(4);

        do_reset(2);
        init_seq(2, 13'h020, t);
        cmd(C_ACT, 2'd0, 13'h000, 2'b00, 16'h0, t);
        push(t, K_ERR, 16'd0);
        cmd(C_ACT, 2'd0, 13'h001, 2'b00, 16'h0, t);
        push(t, K_ERR, 16'd1);
        idle(1);

        do_reset(2);
        init_seq(2, 13'h020, t);
        cmd(C_ACT, 2'd1, 13'h000, 2'b00, 16'h0, t);
        cmd(C_RD,  2'd1, 13'h005, 2'b00, 16'h0, t);
        cmd(C_WR,  2'd1, 13'h007, 2'b00, 16'h1111, t2);
        push(t2, K_ERR, 16'd1); push(t2, K_WRC, 16'd1);
        expect_dq(t + 2, ZV);
        idle(4);
        cmd(C_RD, 2'd1, 13'h007, 2'b00, 16'h0, t);
        expect_dq(t + 2, 16'h1111);
        idle(4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expectations never observed", sb.size());
        end
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s @cycle %0d: got no observation, expected %h", kname(sb[i].kind), sb[i].at, sb[i].val);
        end
        if (errors == 0) $display("PASS");
        else             $display("FAIL");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
